// File: rtl/rnn_pkg.sv
// Shared fixed-point format constants and FSM state type for the RNN datapath blocks.
package rnn_pkg;

  localparam int unsigned FRAC = 8;
  localparam logic signed [15:0] ONE     = 16'sh0100;
  localparam logic signed [15:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StBias,
    StAct,
    StDone
  } state_e;

endpackage

// File: rtl/tensor_1d.sv
// Small register-file vector with combinational read; writes beyond LEN are dropped.
module tensor_1d #(
  parameter int unsigned LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] mem [16];
  logic        in_range;

  assign in_range = (sel < 4'(LEN));
  assign rdata    = in_range ? mem[sel] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
    end else if (we && in_range) begin
      mem[sel] <= wdata;
    end
  end

endmodule

// File: rtl/dense_head.sv
// Dense output head: hard-tanh(h) . w + bias, saturated to Q8.8, then hard-sigmoid.
module dense_head
  import rnn_pkg::*;
#(
  parameter int unsigned LEN  = 4,
  parameter int unsigned FRAC = rnn_pkg::FRAC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  h_sel,
  input  logic [15:0] h_data,
  input  logic        w_write,
  input  logic [3:0]  w_sel,
  input  logic [15:0] w_in,
  input  logic        b_write,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] logit,
  output logic [15:0] y
);

  localparam logic signed [15:0] OneV   = 16'sd1 <<< FRAC;
  localparam logic signed [15:0] NegOne = -OneV;
  localparam logic signed [17:0] One18  = 18'sd1 <<< FRAC;
  localparam logic signed [17:0] Half18 = 18'sd1 <<< (FRAC - 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic signed [35:0] acc_q, acc_d;
  logic signed [15:0] logit_q, logit_d;
  logic signed [15:0] y_q, y_d;
  logic signed [15:0] bias_q;

  logic [3:0]         w_addr;
  logic               w_we;
  logic [15:0]        w_rd;
  logic signed [15:0] h_s, a;
  logic signed [31:0] prod;
  logic signed [35:0] acc_sh;
  logic signed [36:0] sum;
  logic signed [15:0] sat;
  logic signed [17:0] act;
  logic signed [15:0] act_clamped;

  // Weight port belongs to the host while idle and to the MAC walk otherwise.
  assign w_we   = w_write && (state_q == StIdle);
  assign w_addr = (state_q == StMac) ? idx_q : w_sel;

  tensor_1d #(.LEN(LEN)) u_w (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .sel   (w_addr),
    .wdata (w_in),
    .rdata (w_rd)
  );

  always_comb begin
    h_s = $signed(h_data);
    if (h_s > OneV)        a = OneV;
    else if (h_s < NegOne) a = NegOne;
    else                   a = h_s;
    prod   = 32'(a) * 32'($signed(w_rd));
    acc_sh = acc_q >>> FRAC;
    sum    = 37'(acc_sh) + 37'(bias_q);
    if (sum > 37'(SAT_MAX))      sat = SAT_MAX;
    else if (sum < 37'(SAT_MIN)) sat = SAT_MIN;
    else                         sat = sum[15:0];
    act = 18'(logit_q >>> 2) + Half18;
    if (act < 18'sd0)     act_clamped = '0;
    else if (act > One18) act_clamped = OneV;
    else                  act_clamped = act[15:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    logit_d = logit_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StMac: begin
        acc_d = acc_q + 36'(prod);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(LEN - 1)) begin
          state_d = StBias;
          idx_d   = '0;
        end
      end
      StBias: begin
        logit_d = sat;
        state_d = StAct;
      end
      StAct: begin
        y_d     = act_clamped;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      logit_q <= '0;
      y_q     <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      logit_q <= logit_d;
      y_q     <= y_d;
      if (b_write && (state_q == StIdle)) bias_q <= $signed(b_in);
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign h_sel = (state_q == StMac) ? idx_q : '0;
  assign logit = logit_q;
  assign y     = y_q;

endmodule

// File: tb/tb_dense_head.sv
// Directed self-checking bench for dense_head with LEN=4, Q8.8.
module tb_dense_head;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  h_sel;
  logic [15:0] h_data;
  logic        w_write;
  logic [3:0]  w_sel;
  logic [15:0] w_in;
  logic        b_write;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] logit;
  logic [15:0] y;

  logic [15:0] h_mem [16];
  int total = 0;
  int bad   = 0;

  assign h_data = h_mem[h_sel];

  always #5 clk = ~clk;

  dense_head #(.LEN(4), .FRAC(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .h_sel   (h_sel),
    .h_data  (h_data),
    .w_write (w_write),
    .w_sel   (w_sel),
    .w_in    (w_in),
    .b_write (b_write),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .logit   (logit),
    .y       (y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_h(input logic [15:0] v);
    for (int k = 0; k < 16; k++) h_mem[k] = v;
  endtask

  task automatic write_w(input logic [3:0] sel, input logic [15:0] val);
    w_write = 1'b1;
    w_sel   = sel;
    w_in    = val;
    tick();
    w_write = 1'b0;
  endtask

  task automatic write_b(input logic [15:0] val);
    b_write = 1'b1;
    b_in    = val;
    tick();
    b_write = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
    write_w(4'd0, w0);
    write_w(4'd1, w1);
    write_w(4'd2, w2);
    write_w(4'd3, w3);
  endtask

  // Raises start for one cycle (any pending w_write/b_write ride along), then waits for done.
  task automatic run_eval(input string tag, input logic [15:0] exp_logit,
                          input logic [15:0] exp_y, input bit inject, input bit chk_hsel);
    int lat;
    int busy_cnt;
    bit seen;
    start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      start   = 1'b0;
      w_write = 1'b0;
      b_write = 1'b0;
      lat++;
      if (busy) busy_cnt++;
      if (chk_hsel && busy) check({tag, " h_sel"}, 32'(h_sel), (lat <= 4) ? 32'(lat - 1) : 32'd0);
      if (inject && lat == 2) begin
        start   = 1'b1;
        w_write = 1'b1;
        w_sel   = 4'd0;
        w_in    = 16'h0000;
        b_write = 1'b1;
        b_in    = 16'h7f00;
      end
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'd7);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd7);
    check({tag, " logit"}, 32'(logit), 32'(exp_logit));
    check({tag, " y"}, 32'(y), 32'(exp_y));
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst_n   = 1'b0;
    start   = 1'b0;
    w_write = 1'b0;
    w_sel   = '0;
    w_in    = '0;
    b_write = 1'b0;
    b_in    = '0;
    set_h(16'h0080);
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst logit", 32'(logit), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst h_sel", 32'(h_sel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zeroed weights after reset: logit 0, y = 0.5.
    run_eval("zero_w", 16'h0000, 16'h0080, 1'b0, 1'b0);

    load_w(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    write_b(16'h0000);
    run_eval("basic", 16'h0200, 16'h0100, 1'b0, 1'b1);
    repeat (3) tick();
    check("hold logit", 32'(logit), 32'h0200);
    check("hold y", 32'(y), 32'h0100);

    // w[0] cleared, then rewritten in the same cycle as start.
    set_h(16'h0300);
    load_w(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    w_write = 1'b1;
    w_sel   = 4'd0;
    w_in    = 16'h0100;
    run_eval("tanh_clamp", 16'h0100, 16'h00c0, 1'b0, 1'b0);

    // Weight and bias written in the same cycle.
    set_h(16'hff00);
    write_w(4'd0, 16'h0100);
    w_write = 1'b1;
    w_sel   = 4'd1;
    w_in    = 16'h0100;
    b_write = 1'b1;
    b_in    = 16'hff00;
    tick();
    w_write = 1'b0;
    b_write = 1'b0;
    run_eval("low_clamp", 16'hfd00, 16'h0000, 1'b0, 1'b0);

    set_h(16'h0100);
    load_w(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    write_b(16'h0100);
    run_eval("saturate", 16'h7fff, 16'h0100, 1'b0, 1'b0);

    // Start/weight/bias writes while busy must all be dropped.
    set_h(16'h0080);
    load_w(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    write_b(16'h0000);
    run_eval("busy_ignore", 16'h0200, 16'h0100, 1'b1, 1'b0);
    repeat (3) tick();
    check("no_queue busy", 32'(busy), 32'd0);
    run_eval("busy_ignore_rerun", 16'h0200, 16'h0100, 1'b0, 1'b0);

    // Asynchronous reset mid-evaluation.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort logit", 32'(logit), 32'd0);
    check("abort y", 32'(y), 32'd0);
    check("abort h_sel", 32'(h_sel), 32'd0);
    done_cnt = 0;
    repeat (2) begin
      tick();
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    run_eval("post_rst_zero", 16'h0000, 16'h0080, 1'b0, 1'b0);
    load_w(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_eval("post_rst_reload", 16'h0200, 16'h0100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
